// File: rtl/div_unit_pkg.sv
// Shared types and constants for the radix-2 restoring divider:
// state encodings, iteration count and the cleared result value.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam int DIV_ITER_CNT = 32;

    localparam logic [2*DIV_ITER_CNT-1:0] RESULT_ZERO = '0;

endpackage

// File: rtl/div_unit_if.sv
// EX-stage <-> divider request/response bundle; master is the EX stage,
// slave is the divider.
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_ITER_CNT
);
    logic               start;
    logic               signed_div;
    logic               annul;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               busy;

    modport master (
        output start, signed_div, annul, opdata1, opdata2,
        input  result, ready, busy
    );

    modport slave (
        input  start, signed_div, annul, opdata1, opdata2,
        output result, ready, busy
    );
endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division step: shift the next dividend bit into
// the partial remainder and subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // A set top bit means the shifted value already exceeds any WIDTH-bit
    // divisor; the low-word subtraction is exact whenever q_bit is set.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        q_bit   = shifted[WIDTH] | (shifted[WIDTH-1:0] >= divisor);
        diff    = shifted[WIDTH-1:0] - divisor;
        rem_out = q_bit ? diff : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit producing {remainder, quotient} for HI/LO.
// Define DIV_SHORTCUT_EN to finish early when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_ITER_CNT
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   dividend_q, dividend_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               busy_d, ready_d;

    logic               op1_neg, op2_neg;
    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [WIDTH-1:0]   step_rem, quot_final, fixed_quot, fixed_rem;
    logic               step_q;

    // The dividend register doubles as the quotient register: each step
    // shifts a dividend bit out of the top and a quotient bit into the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dividend_q[WIDTH-1]),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        op1_neg    = bus.signed_div & bus.opdata1[WIDTH-1];
        op2_neg    = bus.signed_div & bus.opdata2[WIDTH-1];
        op1_mag    = op1_neg ? (~bus.opdata1 + 1'b1) : bus.opdata1;
        op2_mag    = op2_neg ? (~bus.opdata2 + 1'b1) : bus.opdata2;
        quot_final = {dividend_q[WIDTH-2:0], step_q};
        fixed_quot = neg_quot_q ? (~quot_final + 1'b1) : quot_final;
        fixed_rem  = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        busy_d     = 1'b0;
        ready_d    = 1'b0;

        case (state_q)
            DIV_FREE: begin
                if (bus.start && !bus.annul) begin
                    busy_d = 1'b1;
                    if (bus.opdata2 == '0) begin
                        state_d = DIV_BYZERO;
`ifdef DIV_SHORTCUT_EN
                    end else if (op1_mag < op2_mag) begin
                        result_d = {bus.opdata1, {WIDTH{1'b0}}};
                        state_d  = DIV_END;
`endif
                    end else begin
                        dividend_d = op1_mag;
                        divisor_d  = op2_mag;
                        rem_d      = '0;
                        count_d    = '0;
                        neg_quot_d = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                        state_d    = DIV_ON;
                    end
                end
            end
            DIV_BYZERO: begin
                busy_d = 1'b1;
                if (bus.annul) begin
                    state_d = DIV_FREE;
                end else begin
                    result_d = (2*WIDTH)'(RESULT_ZERO);
                    state_d  = DIV_END;
                end
            end
            DIV_ON: begin
                busy_d = 1'b1;
                if (bus.annul) begin
                    state_d = DIV_FREE;
                end else if (count_q == CW'(WIDTH - 1)) begin
                    result_d = {fixed_rem, fixed_quot};
                    state_d  = DIV_END;
                end else begin
                    rem_d      = step_rem;
                    dividend_d = quot_final;
                    count_d    = count_q + CW'(1);
                end
            end
            DIV_END: begin
                ready_d = 1'b1;
                if (bus.annul || !bus.start) begin
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DIV_FREE;
            count_q    <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= (2*WIDTH)'(RESULT_ZERO);
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_d;
    assign bus.busy   = busy_d;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results and latencies from a reference model,
// expected results queued at request time and popped when ready appears.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] modelDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return '0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    function automatic int expLatency(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ma, mb;
        ma = (sgn && a[W-1]) ? -a : a;
        mb = (sgn && b[W-1]) ? -b : b;
        if (b == '0) return 2;
`ifdef DIV_SHORTCUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return W + 1;
`endif
        return W + 1;
    endfunction

    task automatic applyStimulus(input string tag, input logic sgn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int hold);
        int lat, busy_cnt, edges;
        bit seen;
        logic [2*W-1:0] got, exp;
        exp_q.push_back(modelDiv(sgn, a, b));
        lat = expLatency(sgn, a, b);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
        busy_cnt = 0;
        edges    = 0;
        seen     = 1'b0;
        #1;
        while (!seen && edges < 100) begin
            if (bus.ready) begin
                seen = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                @(posedge clk);
                #1;
                edges++;
                bus.opdata1    = $urandom;
                bus.opdata2    = $urandom;
                bus.signed_div = 1'($urandom);
            end
        end
        exp = exp_q.pop_front();
        checkOutput($sformatf("%s/ready_seen", tag), 64'(seen), 64'd1);
        if (seen) begin
            got = bus.result;
            checkOutput($sformatf("%s/result", tag), got, exp);
            checkOutput($sformatf("%s/latency", tag), 64'(edges), 64'(lat));
            checkOutput($sformatf("%s/busy_cycles", tag), 64'(busy_cnt), 64'(lat));
            checkOutput($sformatf("%s/busy_in_end", tag), 64'(bus.busy), 64'd0);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                checkOutput($sformatf("%s/hold_ready", tag), 64'(bus.ready), 64'd1);
                checkOutput($sformatf("%s/hold_result", tag), bus.result, got);
            end
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s/ready_drop", tag), 64'(bus.ready), 64'd0);
    endtask

    initial begin
        int ready_cnt;
        bus.start      = 1'b0;
        bus.signed_div = 1'b0;
        bus.annul      = 1'b0;
        bus.opdata1    = '0;
        bus.opdata2    = '0;
        resetn         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset/result", bus.result, 64'd0);
        checkOutput("reset/ready", 64'(bus.ready), 64'd0);
        checkOutput("reset/busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        applyStimulus("divu_100_7", 1'b0, 32'd100, 32'd7, 3);
        checkOutput("divu_100_7/literal", bus.result, {32'd2, 32'd14});
        applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1);
        applyStimulus("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        applyStimulus("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 0);
        applyStimulus("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus("div_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
        applyStimulus("div_5_0", 1'b1, 32'd5, 32'd0, 2);

        // Flush ten cycles into a divide; no result may ever appear.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'd1000;
        bus.opdata2    = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("annul/busy_before", 64'(bus.busy), 64'd1);
        bus.annul = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.annul = 1'b0;
        checkOutput("annul/busy_after", 64'(bus.busy), 64'd0);
        ready_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready) ready_cnt++;
        end
        checkOutput("annul/no_ready", 64'(ready_cnt), 64'd0);
        applyStimulus("annul_then_9_3", 1'b0, 32'd9, 32'd3, 0);

        @(negedge clk);
        bus.start      = 1'b1;
        bus.signed_div = 1'b0;
        bus.opdata1    = 32'h0000_FFFF;
        bus.opdata2    = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("rst_mid/busy_before", 64'(bus.busy), 64'd1);
        resetn    = 1'b0;
        bus.start = 1'b0;
        #1;
        checkOutput("rst_mid/result", bus.result, 64'd0);
        checkOutput("rst_mid/ready", 64'(bus.ready), 64'd0);
        checkOutput("rst_mid/busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        ready_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.ready) ready_cnt++;
        end
        checkOutput("rst_mid/no_ready", 64'(ready_cnt), 64'd0);
        applyStimulus("rst_then_9_3", 1'b0, 32'd9, 32'd3, 0);

        applyStimulus("divu_5_9", 1'b0, 32'd5, 32'd9, 1);
        applyStimulus("div_m5_9", 1'b1, 32'hFFFF_FFFB, 32'd9, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), $urandom,
                          32'($urandom_range(1, 1000)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
